// File: rtl/ram_pkg.sv
// Shared definitions for the March C- RAM self-test: controller states,
// RAM operation encoding and per-element operation helpers.
package ram_pkg;

  typedef enum logic [3:0] {
    IDLE,
    M0,
    M1,
    M2,
    M3,
    M4,
    M5,
    DRAIN,
    DONE
  } march_state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  // One w0 element, four r/w elements, one read-only element: 10 ops per word.
  localparam int OPS_PER_WORD = 10;

  localparam logic [7:0] ERR_MAX = 8'hFF;

  function automatic int ops_per_test(input int depth);
    return OPS_PER_WORD * depth;
  endfunction

  // M0 only writes, M5 only reads; M1-M4 read on phase 0 and write on phase 1.
  function automatic op_e op_kind(input march_state_e s, input logic phase);
    op_e k;
    case (s)
      M0:             k = OP_WRITE;
      M1, M2, M3, M4: k = phase ? OP_WRITE : OP_READ;
      default:        k = OP_READ;
    endcase
    return k;
  endfunction

  // Data background for the op: the expected value for a read, the value
  // written for a write. 0 = all-zeros word, 1 = all-ones word.
  function automatic logic op_bit(input march_state_e s, input logic phase);
    logic b;
    case (s)
      M1, M3:  b = phase;
      M2, M4:  b = ~phase;
      default: b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ram_bist_cmp.sv
// Read-data checker: delays the expected word of each read by one cycle to
// line up with the registered RAM output, compares, captures the first
// mismatch and counts all mismatches with saturation.
module ram_bist_cmp
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  rd_vld,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_exp,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_exp,
  output logic [DATA_WIDTH-1:0] fail_got,
  output logic [7:0]            err_count,
  output logic                  clean
);

  logic                  cmp_vld;
  logic [ADDR_WIDTH-1:0] cmp_addr;
  logic [DATA_WIDTH-1:0] cmp_exp;
  logic                  mismatch;

  assign mismatch = cmp_vld && (ram_dout != cmp_exp);

  // Includes the compare happening this cycle so the final read is counted.
  assign clean = (err_count == 8'd0) && !mismatch;

  // Hold the expected word while the RAM produces the read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_vld  <= 1'b0;
      cmp_addr <= '0;
      cmp_exp  <= '0;
    end else if (clear) begin
      cmp_vld  <= 1'b0;
      cmp_addr <= '0;
      cmp_exp  <= '0;
    end else begin
      cmp_vld  <= rd_vld;
      cmp_addr <= rd_addr;
      cmp_exp  <= rd_exp;
    end
  end

  // First mismatch is kept; every mismatch bumps the counter up to ERR_MAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_got  <= '0;
      err_count <= 8'd0;
    end else if (clear) begin
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_got  <= '0;
      err_count <= 8'd0;
    end else if (mismatch) begin
      if (err_count == 8'd0) begin
        fail_addr <= cmp_addr;
        fail_exp  <= cmp_exp;
        fail_got  <= ram_dout;
      end
      if (err_count != ERR_MAX) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: rtl/ram_bist.sv
// March C- built-in self-test controller for a single-port RAM with a
// registered read port. One RAM op is issued per cycle from registered
// outputs; read data is checked by ram_bist_cmp.
//
//   state | meaning
//   IDLE  | waiting for start
//   M0    | up   w0
//   M1    | up   r0,w1 (phase 0 = read, phase 1 = write, same address)
//   M2    | up   r1,w0
//   M3    | down r0,w1
//   M4    | down r1,w0
//   M5    | down r0
//   DRAIN | last read in flight, final compare
//   DONE  | one-cycle done pulse, result latched
module ram_bist
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_exp,
  output logic [DATA_WIDTH-1:0] fail_got,
  output logic [7:0]            err_count
);

  localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(DEPTH - 1);

  march_state_e          state;
  march_state_e          nxt_state;
  logic                  phase;
  logic                  nxt_phase;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic                  rd_vld;
  logic                  accept;
  logic                  clean;

  assign accept = (state == IDLE) && start;

  // Sequence of (element, address, phase) for the op that follows the one
  // currently on the RAM port; ram_addr itself is the address counter.
  always_comb begin
    nxt_state = state;
    nxt_addr  = ram_addr;
    nxt_phase = 1'b0;
    case (state)
      M0: begin
        if (ram_addr == LAST_A) begin
          nxt_state = M1;
          nxt_addr  = '0;
        end else begin
          nxt_addr = ram_addr + 1'b1;
        end
      end
      M1, M2: begin
        if (!phase) begin
          nxt_phase = 1'b1;
        end else if (ram_addr == LAST_A) begin
          nxt_state = (state == M1) ? M2 : M3;
          nxt_addr  = (state == M1) ? '0 : LAST_A;
        end else begin
          nxt_addr = ram_addr + 1'b1;
        end
      end
      M3, M4: begin
        if (!phase) begin
          nxt_phase = 1'b1;
        end else if (ram_addr == '0) begin
          nxt_state = (state == M3) ? M4 : M5;
          nxt_addr  = LAST_A;
        end else begin
          nxt_addr = ram_addr - 1'b1;
        end
      end
      M5: begin
        if (ram_addr == '0) begin
          nxt_state = DRAIN;
        end else begin
          nxt_addr = ram_addr - 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Controller FSM; all RAM-side and status outputs are registered here.
  // For reads ram_din carries the expected word, which feeds the checker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      phase    <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      rd_vld   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= M0;
            phase    <= 1'b0;
            ram_we   <= 1'b1;
            ram_addr <= '0;
            ram_din  <= '0;
            rd_vld   <= 1'b0;
            busy     <= 1'b1;
            pass     <= 1'b0;
          end
        end
        M0, M1, M2, M3, M4, M5: begin
          state    <= nxt_state;
          ram_addr <= nxt_addr;
          phase    <= nxt_phase;
          if (nxt_state == DRAIN) begin
            ram_we <= 1'b0;
            rd_vld <= 1'b0;
          end else begin
            ram_we  <= (op_kind(nxt_state, nxt_phase) == OP_WRITE);
            rd_vld  <= (op_kind(nxt_state, nxt_phase) == OP_READ);
            ram_din <= {DATA_WIDTH{op_bit(nxt_state, nxt_phase)}};
          end
        end
        DRAIN: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= clean;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  ram_bist_cmp #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_cmp (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .rd_vld   (rd_vld),
    .rd_addr  (ram_addr),
    .rd_exp   (ram_din),
    .ram_dout (ram_dout),
    .fail_addr(fail_addr),
    .fail_exp (fail_exp),
    .fail_got (fail_got),
    .err_count(err_count),
    .clean    (clean)
  );

endmodule

// File: tb/tb_ram_bist.sv
// Self-checking bench for ram_bist: a behavioural RAM with an optional
// stuck-at bit, a March C- reference model, and a scoreboard checked on
// every done pulse.
module tb_ram_bist;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          busy;
  logic          done;
  logic          pass;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_exp;
  logic [DW-1:0] fail_got;
  logic [7:0]    err_count;

  ram_bist #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail_addr(fail_addr),
    .fail_exp (fail_exp),
    .fail_got (fail_got),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural RAM with a single optional stuck-at bit seen on reads.
  logic [DW-1:0] mem [DEPTH];
  bit f_en  = 1'b0;
  int f_addr = 0;
  int f_bit  = 0;
  bit f_val  = 1'b0;

  function automatic logic [DW-1:0] faulty(input logic [DW-1:0] v, input int a);
    logic [DW-1:0] r;
    r = v;
    if (f_en && a == f_addr) r[f_bit] = f_val;
    return r;
  endfunction

  always @(posedge clk) begin
    ram_dout <= faulty(mem[ram_addr], int'(ram_addr));
    if (ram_we) mem[ram_addr] <= ram_din;
  end

  typedef struct {
    int            done_cyc;
    bit            pass;
    int            errs;
    logic [AW-1:0] fa;
    logic [DW-1:0] fe;
    logic [DW-1:0] fg;
  } exp_t;

  exp_t exp_q[$];
  int   runs_pushed = 0;
  int   done_seen   = 0;

  // March C- applied to a plain array with the same stuck-at fault.
  function automatic exp_t march_model(input bit fen, input int fa, input int fb, input bit fv);
    logic [7:0] m [16];
    logic [7:0] rdv [6] = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
    logic [7:0] wrv [6] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00};
    logic [7:0] got;
    exp_t e;
    e.done_cyc = 0;
    e.pass = 1'b0;
    e.errs = 0;
    e.fa = '0;
    e.fe = '0;
    e.fg = '0;
    for (int i = 0; i < 16; i++) m[i] = 8'($urandom);
    for (int el = 0; el < 6; el++) begin
      for (int k = 0; k < 16; k++) begin
        int a;
        a = (el < 3) ? k : 15 - k;
        if (el > 0) begin
          got = m[a];
          if (fen && a == fa) got[fb] = fv;
          if (got != rdv[el]) begin
            if (e.errs == 0) begin
              e.fa = 4'(a);
              e.fe = rdv[el];
              e.fg = got;
            end
            e.errs++;
          end
        end
        if (el < 5) m[a] = wrv[el];
      end
    end
    if (e.errs > 255) e.errs = 255;
    e.pass = (e.errs == 0);
    return e;
  endfunction

  // Scoreboard monitor: every done pulse pops one expected result.
  int   busy_cnt = 0;
  int   wr_cnt   = 0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
      wr_cnt   = 0;
    end else begin
      if (busy) busy_cnt++;
      if (ram_we) wr_cnt++;
      if (done) begin
        done_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("done_cycle", cyc, mon_e.done_cyc);
          check("pass", 32'(pass), 32'(mon_e.pass));
          check("err_count", 32'(err_count), mon_e.errs);
          check("fail_addr", 32'(fail_addr), 32'(mon_e.fa));
          check("fail_exp", 32'(fail_exp), 32'(mon_e.fe));
          check("fail_got", 32'(fail_got), 32'(mon_e.fg));
          check("busy_cycles", busy_cnt, DEPTH * 10 + 1);
          check("write_ops", wr_cnt, DEPTH * 5);
          check("busy_in_done", 32'(busy), 0);
        end
        busy_cnt = 0;
        wr_cnt   = 0;
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_ram_we"}, 32'(ram_we), 0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 0);
    check({tag, "_ram_din"}, 32'(ram_din), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_pass"}, 32'(pass), 0);
    check({tag, "_err_count"}, 32'(err_count), 0);
    check({tag, "_fail_addr"}, 32'(fail_addr), 0);
    check({tag, "_fail_exp"}, 32'(fail_exp), 0);
    check({tag, "_fail_got"}, 32'(fail_got), 0);
  endtask

  // One full test; called and left at a falling edge.
  task automatic run_test(input bit fen, input int fa, input int fb, input bit fv,
                          input bit hold, input bit chk_order);
    exp_t e;
    int   c1;
    int   n;
    f_en   = fen;
    f_addr = fa;
    f_bit  = fb;
    f_val  = fv;
    e = march_model(fen, fa, fb, fv);
    repeat ($urandom_range(1, 4)) @(negedge clk);
    e.done_cyc = cyc + 162;
    exp_q.push_back(e);
    runs_pushed++;
    start = 1'b1;
    @(negedge clk);
    c1 = cyc;
    if (!hold) start = 1'b0;
    check("busy_after_start", 32'(busy), 1);
    n = 0;
    while (!done && n < 400) begin
      if (chk_order && cyc == c1 + 80) begin
        check("m3_first_addr", 32'(ram_addr), 15);
        check("m3_first_we", 32'(ram_we), 0);
      end
      if (chk_order && cyc == c1 + 81) begin
        check("m3_second_addr", 32'(ram_addr), 15);
        check("m3_second_we", 32'(ram_we), 1);
        check("m3_second_din", 32'(ram_din), 32'hFF);
      end
      @(negedge clk);
      n++;
    end
    if (!done) begin
      check("done_timeout", 32'(done), 1);
      exp_q.delete();
      start = 1'b0;
    end else if (hold) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    // Fault-free run, with the first M3 ops checked on the RAM port.
    run_test(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    check("clean_pass_held", 32'(pass), 1);

    // Stuck-at-1 on bit 3 of address 5.
    run_test(1'b1, 5, 3, 1'b1, 1'b0, 1'b0);
    check("sa1_pass", 32'(pass), 0);
    check("sa1_fail_addr", 32'(fail_addr), 5);
    check("sa1_fail_exp", 32'(fail_exp), 32'h00);
    check("sa1_fail_got", 32'(fail_got), 32'h08);
    check("sa1_err_count", 32'(err_count), 3);

    // Start held high across the whole run, including the DONE cycle.
    run_test(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    repeat (200) @(negedge clk);
    check("hold_single_run", done_seen, runs_pushed);
    check("hold_idle_busy", 32'(busy), 0);

    // Reset 50 cycles into a test, then a clean rerun.
    f_en  = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    check("abort_busy_before_rst", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check_reset_values("abort");
    @(negedge clk);
    rst = 1'b0;
    run_test(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

    // Randomized fault locations and polarities.
    for (int r = 0; r < 6; r++) begin
      run_test($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)),
               int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    check("done_count", done_seen, runs_pushed);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_bist.md
RAM_BIST -- requirements
Module: ram_bist

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, the RAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, the RAM data width.
REQ-003 SHALL have parameter DEPTH, default 16, the number of RAM words tested (0..DEPTH-1).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle request to run the test, honoured only in IDLE.
REQ-007 SHALL have port ram_we  output  ADDR-independent 1  write enable to the single-port RAM.
REQ-008 SHALL have port ram_addr  output  ADDR_WIDTH  RAM address.
REQ-009 SHALL have port ram_din  output  DATA_WIDTH  RAM write data.
REQ-010 SHALL have port ram_dout  input  DATA_WIDTH  RAM read data (registered, valid one cycle after a read is sampled).
REQ-011 SHALL have port busy  output  1  test in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse at test end.
REQ-013 SHALL have port pass  output  1  result of the last completed test, held until the next start.
REQ-014 SHALL have port fail_addr, fail_exp, fail_got  output  ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH  first-mismatch capture.
REQ-015 SHALL have port err_count  output  8  mismatches seen, saturating at 255.

Function
REQ-016 SHALL run March C- ops: M0 up w0; M1 up r0,w1; M2 up r1,w0; M3 down r0,w1; M4 down r1,w0; M5 down r0 (0 = all-zeros word, 1 = all-ones word).
REQ-017 SHALL use FSM states IDLE, M0, M1, M2, M3, M4, M5, DRAIN, DONE; within M1-M4 a phase bit alternates read then write at the same address.
REQ-018 SHALL issue exactly one RAM op per cycle via registered ram_we/ram_addr/ram_din; reads drive ram_we=0; 16+32*4+16 = 160 ops for DEPTH=16.
REQ-019 SHALL step "up" elements 0..DEPTH-1 and "down" elements DEPTH-1..0, advancing to the next element after the last address with no idle cycle.
REQ-020 SHALL register expected data and a compare-valid flag for each read and compare against ram_dout on the following edge.
REQ-021 SHALL, on a mismatch with err_count==0, capture fail_addr/fail_exp/fail_got; later mismatches only increment err_count.
REQ-022 SHALL enter DRAIN after the last M5 read, perform the final compare, then DONE for one cycle (done=1), then IDLE.
REQ-023 SHALL, for DEPTH=16, assert done in the cycle after the 161st rising edge following the edge that sampled start.
REQ-024 SHALL set pass=1 at DONE iff err_count==0; clear pass, err_count and fail_* when start is accepted.
REQ-025 SHALL assert busy from the cycle after start is accepted through DRAIN inclusive; busy=0 in DONE and IDLE.
REQ-026 SHALL ignore start when not in IDLE; start coincident with DONE is ignored.
REQ-027 SHALL hold ram_we=0 in IDLE, DRAIN and DONE.

Reset
REQ-028 SHALL on rst force state IDLE, ram_we=0, ram_addr=0, ram_din=0, busy=0, done=0, pass=0, err_count=0, fail_*=0, compare-valid=0.
REQ-029 SHALL on rst mid-test abort immediately without further RAM writes; RAM contents are then undefined.

Structure
REQ-030 SHALL place the march-state enum, op encoding (READ/WRITE) and ops-per-test constant in shared package ram_pkg.
REQ-031 SHALL instantiate one sub-module, ram_bist_cmp, holding the expected-data pipeline register, the comparator, first-fail capture and the saturating counter.

Verification
REQ-032 SHALL test a fault-free RAM model: start pulse -> done 161 edges later, pass=1, err_count=0.
REQ-033 SHALL test stuck-at-1 on bit 3 of addr 5: pass=0, fail_addr=5, fail_exp=0x00, fail_got=0x08, err_count=3.
REQ-034 SHALL test address order: first M3 op -> ram_addr=15, ram_we=0; next cycle -> ram_addr=15, ram_we=1, ram_din=0xFF.
REQ-035 SHALL test start held high while busy: exactly one test run, done pulses once.
REQ-036 SHALL test rst asserted 50 cycles into a test: all outputs at reset values immediately; a new start -> full 161-edge run, pass=1.
